// File: rtl/mips_hazard_pkg.sv
// Shared definitions for the MIPS hazard controller: FSM encoding,
// multi-cycle unit latency defaults and the busy-counter width helper.
package mips_hazard_pkg;

  // Mult/div sequencer states
  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_MD_BUSY = 1'b1;

  // Default latencies of the multi-cycle unit, in cycles after issue
  localparam int unsigned MULT_CYCLES_DEF = 4;
  localparam int unsigned DIV_CYCLES_DEF  = 32;

  // Busy counter must hold DIV_CYCLES-1, with one bit of headroom
  function automatic int unsigned cnt_width(input int unsigned div_cycles);
    return $clog2(div_cycles) + 1;
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(DIV_CYCLES_DEF);

endpackage

// File: rtl/md_seq.sv
// Mult/div sequencer: tracks how long the multi-cycle unit stays busy after
// an issue from EX and pulses md_done on the first cycle back in RUN.
module md_seq
  import mips_hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start_ex,
  input  logic md_div_ex,
  output logic md_busy,
  output logic md_done
);

  localparam int unsigned CNT_W = cnt_width(DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  logic             state;
  logic             state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             done_next;

  // Next-state: load the latency on issue, count down while busy.
  // A start seen while busy is ignored; ID is held by md_hazard then.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    case (state)
      ST_RUN: begin
        if (md_start_ex) begin
          cnt_next   = md_div_ex ? DIV_LOAD : MULT_LOAD;
          state_next = ST_MD_BUSY;
        end
      end
      ST_MD_BUSY: begin
        if (cnt == '0) begin
          state_next = ST_RUN;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // State, counter and done-pulse registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      cnt     <= '0;
      md_done <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      md_done <= done_next;
    end
  end

  assign md_busy = (state == ST_MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO stalls, taken-branch
// flush, mult/div sequencing and a saturating stall-cycle counter.
module hazard_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread_ex,
  input  logic [4:0]  rt_ex,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        uses_rt_id,
  input  logic        branch_taken_id,
  input  logic        md_start_ex,
  input  logic        md_div_ex,
  input  logic        hilo_use_id,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_count
);

  logic load_use;
  logic md_hazard;
  logic stall;

  md_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_seq (
    .clk         (clk),
    .rst         (rst),
    .md_start_ex (md_start_ex),
    .md_div_ex   (md_div_ex),
    .md_busy     (md_busy),
    .md_done     (md_done)
  );

  // Hazard decode; a held branch re-resolves next cycle, so stall beats flush
  always_comb begin
    load_use    = memread_ex && (rt_ex != 5'd0) &&
                  ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));
    md_hazard   = md_busy && hilo_use_id;
    stall       = load_use || md_hazard;
    pc_write    = !stall;
    ifid_write  = !stall;
    idex_bubble = stall;
    ifid_flush  = branch_taken_id && !stall;
  end

  // Saturating count of stall cycles for performance debug
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-count reference model.
module tb_hazard_ctrl;

  localparam int unsigned MULT_C = 4;
  localparam int unsigned DIV_C  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread_ex, uses_rt_id, branch_taken_id;
  logic        md_start_ex, md_div_ex, hilo_use_id;
  logic [4:0]  rt_ex, rs_id, rt_id;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush, md_busy, md_done;
  logic [31:0] stall_count;

  int passed = 0;
  int total  = 0;

  // Reference model state
  int          m_busy_left = 0;
  logic        m_done;
  logic [31:0] m_stalls;
  logic        sat_load = 1'b0;

  hazard_ctrl #(
    .MULT_CYCLES (MULT_C),
    .DIV_CYCLES  (DIV_C)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .memread_ex      (memread_ex),
    .rt_ex           (rt_ex),
    .rs_id           (rs_id),
    .rt_id           (rt_id),
    .uses_rt_id      (uses_rt_id),
    .branch_taken_id (branch_taken_id),
    .md_start_ex     (md_start_ex),
    .md_div_ex       (md_div_ex),
    .hilo_use_id     (hilo_use_id),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .idex_bubble     (idex_bubble),
    .ifid_flush      (ifid_flush),
    .md_busy         (md_busy),
    .md_done         (md_done),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic f_stall();
    logic lu;
    lu = memread_ex && (rt_ex != 5'd0) &&
         ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));
    return lu || ((m_busy_left > 0) && hilo_use_id);
  endfunction

  // Model: remaining busy cycles, done pulse and saturating stall total
  always @(posedge clk) begin
    if (rst) begin
      m_busy_left <= 0;
      m_done      <= 1'b0;
      m_stalls    <= 32'd0;
    end else begin
      if (m_busy_left > 0) begin
        m_busy_left <= m_busy_left - 1;
        m_done      <= (m_busy_left == 1);
      end else begin
        m_done <= 1'b0;
        if (md_start_ex) m_busy_left <= md_div_ex ? DIV_C : MULT_C;
      end
      if (sat_load) m_stalls <= 32'hFFFF_FFFE;
      else if (f_stall() && (m_stalls != 32'hFFFF_FFFF)) m_stalls <= m_stalls + 32'd1;
    end
  end

  // Issue while busy must never be driven by the stimulus
  always @(posedge clk) begin
    assert (rst || !(md_start_ex && (m_busy_left > 0)))
      else $error("md_start_ex driven while unit busy");
  end

  initial begin
    #500000;
    $display("FAIL timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end

  task automatic idle();
    memread_ex = 0; rt_ex = 0; rs_id = 0; rt_id = 0; uses_rt_id = 0;
    branch_taken_id = 0; md_start_ex = 0; md_div_ex = 0; hilo_use_id = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (md_busy !== 1'b0) $display("FAIL rst_md_busy got=%b exp=0", md_busy); else passed++;
    total++; if (md_done !== 1'b0) $display("FAIL rst_md_done got=%b exp=0", md_done); else passed++;
    total++;
    if (stall_count !== 32'd0) $display("FAIL rst_stall_count got=%h exp=0", stall_count);
    else passed++;
    total++;
    if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== 4'b1100)
      $display("FAIL rst_ctrl got=%b exp=1100", {pc_write, ifid_write, idex_bubble, ifid_flush});
    else passed++;
  endtask

  task automatic test_load_use();
    @(negedge clk); idle(); memread_ex = 1; rt_ex = 5'd8; rs_id = 5'd8; #1;
    total++;
    if ({pc_write, ifid_write, idex_bubble} !== 3'b001)
      $display("FAIL lu_stall got=%b exp=001", {pc_write, ifid_write, idex_bubble});
    else passed++;
    @(negedge clk); memread_ex = 0; #1;
    total++;
    if ({pc_write, idex_bubble} !== 2'b10)
      $display("FAIL lu_one_cycle got=%b exp=10", {pc_write, idex_bubble});
    else passed++;
    total++;
    if (stall_count !== 32'd1) $display("FAIL lu_count got=%0d exp=1", stall_count);
    else passed++;
    @(negedge clk); memread_ex = 1; rt_ex = 5'd0; rs_id = 5'd0; #1;
    total++;
    if (idex_bubble !== 1'b0) $display("FAIL lu_r0 got=%b exp=0", idex_bubble); else passed++;
  endtask

  task automatic test_rt_only();
    @(negedge clk); idle(); memread_ex = 1; rt_ex = 5'd8; rs_id = 5'd3; rt_id = 5'd8; #1;
    total++;
    if (pc_write !== 1'b1) $display("FAIL rt_unused got=%b exp=1", pc_write); else passed++;
    uses_rt_id = 1; #1;
    total++;
    if (pc_write !== 1'b0) $display("FAIL rt_used got=%b exp=0", pc_write); else passed++;
    @(negedge clk); memread_ex = 0; #1;
    total++;
    if (pc_write !== 1'b1) $display("FAIL rt_release got=%b exp=1", pc_write); else passed++;
  endtask

  task automatic test_md(input bit is_div);
    int n;
    int stalls;
    bit ok;
    logic [31:0] s0;
    n = is_div ? DIV_C : MULT_C;
    stalls = 0;
    ok = 0;
    @(negedge clk); idle(); md_start_ex = 1; md_div_ex = is_div; hilo_use_id = 1; #1;
    total++;
    if (pc_write !== 1'b1) $display("FAIL md_issue_nostall got=%b exp=1", pc_write); else passed++;
    s0 = m_stalls;
    @(negedge clk); md_start_ex = 0; md_div_ex = 0;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (pc_write === 1'b1) begin ok = 1; break; end
      stalls++;
      total++;
      if (md_busy !== 1'b1) $display("FAIL md_busy_during c=%0d got=%b exp=1", c, md_busy);
      else passed++;
      @(negedge clk);
    end
    total++; if (!ok) $display("FAIL md_release got=stuck exp=released"); else passed++;
    total++;
    if (stalls != n) $display("FAIL md_stall_len got=%0d exp=%0d", stalls, n); else passed++;
    total++; if (md_done !== 1'b1) $display("FAIL md_done_pulse got=%b exp=1", md_done); else passed++;
    total++; if (md_busy !== 1'b0) $display("FAIL md_busy_end got=%b exp=0", md_busy); else passed++;
    total++;
    if (stall_count !== s0 + n) $display("FAIL md_count got=%0d exp=%0d", stall_count, s0 + n);
    else passed++;
    @(negedge clk); hilo_use_id = 0; #1;
    total++; if (md_done !== 1'b0) $display("FAIL md_done_width got=%b exp=0", md_done); else passed++;
  endtask

  task automatic test_branch();
    @(negedge clk); idle(); memread_ex = 1; rt_ex = 5'd8; rs_id = 5'd8; branch_taken_id = 1; #1;
    total++;
    if ({ifid_flush, pc_write} !== 2'b00)
      $display("FAIL br_stalled got=%b exp=00", {ifid_flush, pc_write});
    else passed++;
    @(negedge clk); memread_ex = 0; #1;
    total++; if (ifid_flush !== 1'b1) $display("FAIL br_flush got=%b exp=1", ifid_flush); else passed++;
    @(negedge clk); branch_taken_id = 0; #1;
    total++; if (ifid_flush !== 1'b0) $display("FAIL br_clear got=%b exp=0", ifid_flush); else passed++;
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk); idle(); md_start_ex = 1; md_div_ex = 1; hilo_use_id = 1;
    @(negedge clk); md_start_ex = 0; md_div_ex = 0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    #1;
    total++; if (md_busy !== 1'b1) $display("FAIL rmd_busy10 got=%b exp=1", md_busy); else passed++;
    rst = 1;
    @(negedge clk); rst = 0; #1;
    total++;
    if ({md_busy, md_done, pc_write} !== 3'b001)
      $display("FAIL rmd_after got=%b exp=001", {md_busy, md_done, pc_write});
    else passed++;
    total++;
    if (stall_count !== 32'd0) $display("FAIL rmd_count got=%h exp=0", stall_count); else passed++;
    @(negedge clk); #1;
    total++; if (md_done !== 1'b0) $display("FAIL rmd_nodone got=%b exp=0", md_done); else passed++;
    hilo_use_id = 0;
  endtask

  task automatic test_random();
    logic es;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      memread_ex = 1'($urandom_range(0, 1));
      rt_ex = 5'($urandom_range(0, 3));
      rs_id = 5'($urandom_range(0, 3));
      rt_id = 5'($urandom_range(0, 3));
      uses_rt_id = 1'($urandom_range(0, 1));
      branch_taken_id = 1'($urandom_range(0, 1));
      hilo_use_id = 1'($urandom_range(0, 1));
      md_start_ex = (m_busy_left == 0) && ($urandom_range(0, 7) == 0);
      md_div_ex = md_start_ex && ($urandom_range(0, 3) == 0);
      #1;
      es = f_stall();
      total++;
      if ({pc_write, ifid_write, idex_bubble} !== {!es, !es, es})
        $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, {pc_write, ifid_write, idex_bubble},
                 {!es, !es, es});
      else passed++;
      total++;
      if (ifid_flush !== (branch_taken_id && !es))
        $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, ifid_flush, branch_taken_id && !es);
      else passed++;
      total++;
      if (md_busy !== (m_busy_left > 0))
        $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, md_busy, m_busy_left > 0);
      else passed++;
      total++;
      if (md_done !== m_done) $display("FAIL rnd_done c=%0d got=%b exp=%b", c, md_done, m_done);
      else passed++;
      total++;
      if (stall_count !== m_stalls)
        $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, stall_count, m_stalls);
      else passed++;
    end
    @(negedge clk); idle();
  endtask

  task automatic test_saturation();
    // Drain any in-flight mult/div so the force cycle sees no stall
    for (int c = 0; c < 40; c++) @(negedge clk);
    idle();
    force dut.stall_count = 32'hFFFF_FFFE;
    sat_load = 1;
    @(negedge clk);
    release dut.stall_count;
    sat_load = 0;
    memread_ex = 1; rt_ex = 5'd5; rs_id = 5'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      total++;
      if (stall_count !== 32'hFFFF_FFFF)
        $display("FAIL sat_hold c=%0d got=%h exp=ffffffff", c, stall_count);
      else passed++;
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_rt_only();
    test_md(1'b0);
    test_md(1'b1);
    test_branch();
    test_reset_mid_div();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
